// File: rtl/fecg_pkg.sv
// Shared types for the fetal-ECG front end: sample/accumulator types, covariance FSM states
// and the 32-bit saturating reduction used when COV_SATURATE_EN is defined.
package fecg_pkg;

    localparam int unsigned DEF_DATA_W = 16;
    localparam int unsigned DEF_ACC_W  = 48;
    // Widest supported accumulator; narrower accumulators sign-extend into acc_t.
    localparam int unsigned ACC_MAX_W  = 64;

    typedef logic signed [DEF_DATA_W-1:0] sample_t;
    typedef logic signed [ACC_MAX_W-1:0]  acc_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        SCALE = 2'd2,
        DONE  = 2'd3
    } cov_state_e;

    localparam acc_t SAT_MAX = acc_t'(64'sd2147483647);
    localparam acc_t SAT_MIN = -acc_t'(64'sd2147483648);

    function automatic logic signed [31:0] sat32(input acc_t v);
        if (v > SAT_MAX) begin
            return 32'sh7fff_ffff;
        end else if (v < SAT_MIN) begin
            return 32'sh8000_0000;
        end
        return v[31:0];
    endfunction

endpackage

// File: rtl/cov_mac_cell.sv
// One upper-triangle covariance element: signed multiply-accumulate of xi*xj with
// synchronous clear and accumulate enable.
module cov_mac_cell #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ACC_W  = 48
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     clr,
    input  logic                     en,
    input  logic signed [DATA_W-1:0] xi,
    input  logic signed [DATA_W-1:0] xj,
    output logic signed [ACC_W-1:0]  acc
);

    localparam int unsigned PROD_W = 2 * DATA_W;

    logic signed [PROD_W-1:0] prod;

    assign prod = PROD_W'(xi) * PROD_W'(xj);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (clr) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc + ACC_W'(prod);
        end
    end

endmodule

// File: rtl/cov_accumulator.sv
// Streaming covariance estimator: accumulates x*x^T over N_SAMPLES vectors, divides by
// N_SAMPLES and holds the mirrored 32-bit matrix. Define COV_SATURATE_EN to saturate instead of wrap.
module cov_accumulator
    import fecg_pkg::*;
#(
    parameter int unsigned N_CH      = 8,
    parameter int unsigned N_SAMPLES = 256,
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned ACC_W     = DEF_ACC_W
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic                               start,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic [N_CH-1:0][DATA_W-1:0]        in_data,
    output logic                               out_valid,
    input  logic                               out_ready,
    output logic [N_CH-1:0][N_CH-1:0][31:0]    mat_out,
    output logic                               busy
);

    localparam int unsigned SHIFT = $clog2(N_SAMPLES);
    localparam int unsigned CNT_W = SHIFT;
    localparam int unsigned N_TRI = N_CH * (N_CH + 1) / 2;

    if ((N_SAMPLES < 2) || ((N_SAMPLES & (N_SAMPLES - 1)) != 0)) begin : g_bad_n_samples
        $error("cov_accumulator: N_SAMPLES must be a power of two >= 2");
    end
    if ((ACC_W < 2 * DATA_W + SHIFT) || (ACC_W > ACC_MAX_W)) begin : g_bad_acc_w
        $error("cov_accumulator: ACC_W must be in [2*DATA_W+log2(N_SAMPLES), 64]");
    end

    cov_state_e              state;
    logic [CNT_W-1:0]        count;
    logic                    accept_c;
    logic                    clr_c;
    logic signed [ACC_W-1:0] acc_tri [N_TRI];

    assign accept_c = in_valid && in_ready;
    assign clr_c    = (state == IDLE) && start;

    // Divide by N_SAMPLES (floor) and narrow to 32 bits.
    function automatic logic signed [31:0] reduce32(input logic signed [ACC_W-1:0] a);
        logic signed [ACC_W-1:0] sh;
        sh = a >>> SHIFT;
`ifdef COV_SATURATE_EN
        return sat32(acc_t'(sh));
`else
        return 32'(sh);
`endif
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            count     <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= ACCUM;
                        count    <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (accept_c) begin
                        count <= count + CNT_W'(1);
                        if (count == CNT_W'(N_SAMPLES - 1)) begin
                            state    <= SCALE;
                            in_ready <= 1'b0;
                        end
                    end
                end
                SCALE: begin
                    state     <= DONE;
                    out_valid <= 1'b1;
                end
                DONE: begin
                    // out_ready takes priority; a simultaneous start is dropped.
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Upper-triangle MAC cells, one scaled register per cell mirrored into both halves.
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_row
        for (genvar gj = gi; gj < N_CH; gj++) begin : g_col
            localparam int IDX = gi * (2 * N_CH - gi + 1) / 2 + (gj - gi);

            logic signed [31:0] mat_q;

            cov_mac_cell #(
                .DATA_W (DATA_W),
                .ACC_W  (ACC_W)
            ) u_cell (
                .clk    (clk),
                .rst_n  (rst_n),
                .clr    (clr_c),
                .en     (accept_c),
                .xi     ($signed(in_data[gi])),
                .xj     ($signed(in_data[gj])),
                .acc    (acc_tri[IDX])
            );

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    mat_q <= '0;
                end else if (state == SCALE) begin
                    mat_q <= reduce32(acc_tri[IDX]);
                end
            end

            assign mat_out[gi][gj] = mat_q;
            if (gi != gj) begin : g_mirror
                assign mat_out[gj][gi] = mat_q;
            end
        end
    end

endmodule
